// File: rtl/ddr_frame_reader_mb.sv
// Multi-buffer frame reader: fetches one line per request from the newest completed
// frame buffer as pipelined Avalon-MM read bursts, and emits a marked pixel stream.
module ddr_frame_reader_mb #(
  parameter int unsigned       ADDR_W          = 30,
  parameter int unsigned       DATA_W          = 64,
  parameter int unsigned       PIX_W           = 24,
  parameter int unsigned       BURST_LEN       = 128,
  parameter int unsigned       BURSTS_PER_LINE = 10,
  parameter int unsigned       LINES           = 720,
  parameter int unsigned       LINE_STRIDE     = 1280,
  parameter int unsigned       NUM_BUF         = 3,
  parameter logic [ADDR_W-1:0] BUF_BASE        = '0,
  parameter logic [ADDR_W-1:0] BUF_STRIDE      = ADDR_W'('h100000),
  parameter int unsigned       MAX_OUTST       = 4
) (
  input  logic              clk_100,
  input  logic              reset,
  input  logic              line_request,
  input  logic              done_write_frame,
  input  logic [1:0]        wr_buf_idx,
  output logic [1:0]        rd_buf_idx,
  output logic              frame_buffer_ready,
  output logic              busy,
  output logic              avm_read,
  output logic [ADDR_W-1:0] avm_address,
  output logic [7:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic [7:0]        count_read_frame,
  output logic [1:0]        fsm_state
);

  localparam int unsigned WORDS  = BURST_LEN * BURSTS_PER_LINE;
  localparam int unsigned WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned OUT_W  = $clog2(MAX_OUTST + 1);
  localparam int unsigned ISS_W  = $clog2(BURSTS_PER_LINE + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state;
  logic [1:0]        latest;
  logic [LINE_W-1:0] line_cnt;
  logic [WORD_W-1:0] word_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [OUT_W-1:0]  outstanding;
  logic [ISS_W-1:0]  issued;

  logic              accept;
  logic              beat_valid;
  logic              beat_last;
  logic              word_last;
  logic              burst_done;
  logic [OUT_W-1:0]  outst_next;
  logic [ISS_W-1:0]  issued_next;
  logic [1:0]        start_buf;
  logic [ADDR_W-1:0] line_addr;
  logic              unused_hi;

  // Handshake: a burst is accepted on avm_read && !avm_waitrequest; while stalled,
  // avm_read/avm_address/avm_burstcount stay stable. Beats only count while a burst
  // is outstanding, so words still returning from before a reset are dropped.
  assign accept      = avm_read && !avm_waitrequest;
  assign beat_valid  = avm_readdatavalid && (outstanding != '0);
  assign beat_last   = beat_cnt == BEAT_W'(BURST_LEN - 1);
  assign word_last   = word_cnt == WORD_W'(WORDS - 1);
  assign burst_done  = beat_valid && beat_last;
  assign outst_next  = outstanding + OUT_W'(accept) - OUT_W'(burst_done);
  assign issued_next = issued + ISS_W'(accept);
  assign start_buf   = (line_cnt == '0) ? latest : rd_buf_idx;
  assign line_addr   = BUF_BASE + ADDR_W'(start_buf) * BUF_STRIDE
                     + ADDR_W'(line_cnt) * ADDR_W'(LINE_STRIDE);

  assign avm_burstcount = 8'(BURST_LEN);
  assign fsm_state      = state;
  assign unused_hi      = ^avm_readdata[DATA_W-1:PIX_W];

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state              <= S_IDLE;
      latest             <= '0;
      frame_buffer_ready <= 1'b0;
      rd_buf_idx         <= '0;
      busy               <= 1'b0;
      avm_read           <= 1'b0;
      avm_address        <= '0;
      line_cnt           <= '0;
      word_cnt           <= '0;
      beat_cnt           <= '0;
      outstanding        <= '0;
      issued             <= '0;
      pix_data           <= '0;
      pix_valid          <= 1'b0;
      pix_sof            <= 1'b0;
      pix_eol            <= 1'b0;
      count_read_frame   <= '0;
    end else begin
      if (done_write_frame && (32'(wr_buf_idx) < NUM_BUF)) begin
        latest             <= wr_buf_idx;
        frame_buffer_ready <= 1'b1;
      end

      outstanding <= outst_next;
      if (beat_valid) begin
        beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
        word_cnt <= word_last ? '0 : word_cnt + 1'b1;
        pix_data <= avm_readdata[PIX_W-1:0];
      end
      pix_valid <= beat_valid;
      pix_sof   <= beat_valid && (word_cnt == '0) && (line_cnt == '0);
      pix_eol   <= beat_valid && word_last;

      case (state)
        S_IDLE: begin
          if (frame_buffer_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (line_request) begin
            state       <= S_ISSUE;
            busy        <= 1'b1;
            avm_read    <= 1'b1;
            avm_address <= line_addr;
            issued      <= '0;
            if (line_cnt == '0) rd_buf_idx <= latest;
          end
        end
        S_ISSUE: begin
          if (accept) avm_address <= avm_address + ADDR_W'(BURST_LEN);
          issued <= issued_next;
          if (issued_next == ISS_W'(BURSTS_PER_LINE)) begin
            state    <= S_DRAIN;
            avm_read <= 1'b0;
          end else begin
            avm_read <= outst_next < OUT_W'(MAX_OUTST);
          end
        end
        S_DRAIN: begin
          if (beat_valid && word_last) begin
            state <= S_WAIT;
            busy  <= 1'b0;
            if (line_cnt == LINE_W'(LINES - 1)) begin
              line_cnt         <= '0;
              count_read_frame <= count_read_frame + 8'd1;
            end else begin
              line_cnt <= line_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_frame_reader_mb.sv
// Bench for ddr_frame_reader_mb: a pipelined instance (MAX_OUTST=2) and a single-burst
// instance (MAX_OUTST=1) against behavioural Avalon read slaves.
module tb_ddr_frame_reader_mb;

  localparam int BL = 4;

  // ---------------- clock / reset ----------------
  logic clk_100 = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_100 = ~clk_100;

  // ---------------- DUT A signals ----------------
  logic        line_request = 1'b0, done_write_frame = 1'b0;
  logic [1:0]  wr_buf_idx = 2'd0, rd_buf_idx, fsm_state;
  logic        frame_buffer_ready, busy, avm_read, pix_valid, pix_sof, pix_eol;
  logic [29:0] avm_address;
  logic [7:0]  avm_burstcount, count_read_frame;
  logic        avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
  logic [63:0] avm_readdata = '0;
  logic [23:0] pix_data;

  // ---------------- DUT B signals ----------------
  logic        line_request_b = 1'b0, done_write_frame_b = 1'b0;
  logic [1:0]  wr_buf_idx_b = 2'd0, rd_buf_idx_b, fsm_state_b;
  logic        frame_buffer_ready_b, busy_b, avm_read_b, pix_valid_b, pix_sof_b, pix_eol_b;
  logic [29:0] avm_address_b;
  logic [7:0]  avm_burstcount_b, count_read_frame_b;
  logic        avm_waitrequest_b = 1'b0, avm_readdatavalid_b = 1'b0;
  logic [63:0] avm_readdata_b = '0;
  logic [23:0] pix_data_b;

  ddr_frame_reader_mb #(
    .BURST_LEN(4), .BURSTS_PER_LINE(2), .LINES(3), .MAX_OUTST(2)
  ) dut (
    .clk_100(clk_100), .reset(reset), .line_request(line_request),
    .done_write_frame(done_write_frame), .wr_buf_idx(wr_buf_idx), .rd_buf_idx(rd_buf_idx),
    .frame_buffer_ready(frame_buffer_ready), .busy(busy), .avm_read(avm_read),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .count_read_frame(count_read_frame),
    .fsm_state(fsm_state)
  );

  ddr_frame_reader_mb #(
    .BURST_LEN(4), .BURSTS_PER_LINE(2), .LINES(3), .MAX_OUTST(1)
  ) dut_b (
    .clk_100(clk_100), .reset(reset), .line_request(line_request_b),
    .done_write_frame(done_write_frame_b), .wr_buf_idx(wr_buf_idx_b), .rd_buf_idx(rd_buf_idx_b),
    .frame_buffer_ready(frame_buffer_ready_b), .busy(busy_b), .avm_read(avm_read_b),
    .avm_address(avm_address_b), .avm_burstcount(avm_burstcount_b),
    .avm_waitrequest(avm_waitrequest_b), .avm_readdata(avm_readdata_b),
    .avm_readdatavalid(avm_readdatavalid_b), .pix_data(pix_data_b), .pix_valid(pix_valid_b),
    .pix_sof(pix_sof_b), .pix_eol(pix_eol_b), .count_read_frame(count_read_frame_b),
    .fsm_state(fsm_state_b)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [25:0] exp_q[$];       // {sof, eol, pixel}
  logic [29:0] exp_addr_q[$];
  logic [29:0] exp_addr_b_q[$];
  int n_acc_a = 0, n_pix_a = 0;
  int n_acc_b = 0, n_pix_b = 0, outst_b = 0, beats_b = 0;

  function automatic logic [63:0] mem_word(input logic [29:0] a);
    return {4'hA, a ^ 30'h155, a ^ 30'h2A5A5A5};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- Avalon slave model A ----------------
  int          mem_lat_a = 2;
  int          cyc_a = 0, beat_a = 0;
  logic [29:0] acc_a_addr[$];
  int          acc_a_t[$];
  logic        rdv_last_a = 1'b0;

  always @(posedge clk_100) begin
    cyc_a++;
    if (avm_read && !avm_waitrequest) begin
      acc_a_addr.push_back(avm_address);
      acc_a_t.push_back(cyc_a);
    end
    #1;
    avm_readdatavalid = 1'b0;
    rdv_last_a        = 1'b0;
    if (acc_a_addr.size() != 0 && cyc_a >= acc_a_t[0] + mem_lat_a) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = mem_word(acc_a_addr[0] + 30'(beat_a));
      if (beat_a == BL - 1) begin
        beat_a     = 0;
        rdv_last_a = 1'b1;
        void'(acc_a_addr.pop_front());
        void'(acc_a_t.pop_front());
      end else begin
        beat_a++;
      end
    end
  end

  // ---------------- Avalon slave model B (slow) ----------------
  int          cyc_b = 0, beat_b = 0;
  logic [29:0] acc_b_addr[$];
  int          acc_b_t[$];

  always @(posedge clk_100) begin
    cyc_b++;
    if (avm_read_b && !avm_waitrequest_b) begin
      acc_b_addr.push_back(avm_address_b);
      acc_b_t.push_back(cyc_b);
    end
    #1;
    avm_readdatavalid_b = 1'b0;
    if (acc_b_addr.size() != 0 && cyc_b >= acc_b_t[0] + 9) begin
      avm_readdatavalid_b = 1'b1;
      avm_readdata_b      = mem_word(acc_b_addr[0] + 30'(beat_b));
      if (beat_b == BL - 1) begin
        beat_b = 0;
        void'(acc_b_addr.pop_front());
        void'(acc_b_t.pop_front());
      end else begin
        beat_b++;
      end
    end
  end

  // ---------------- monitor A ----------------
  logic        prev_rdv = 1'b0;
  logic [23:0] prev_lo  = '0;

  always @(negedge clk_100) begin
    if (avm_read && !avm_waitrequest && !reset) begin
      n_acc_a++;
      if (exp_addr_q.size() == 0) check("extra_burst_addr", avm_address, 30'h3FFFFFFF);
      else check("burst_addr", avm_address, exp_addr_q.pop_front());
    end
    if (pix_valid) begin
      n_pix_a++;
      check("pix_latency", {prev_rdv, prev_lo}, {1'b1, pix_data});
      if (exp_q.size() == 0) check("extra_pixel", {pix_sof, pix_eol, pix_data}, 26'h3FFFFFF);
      else check("pixel_sof_eol_data", {pix_sof, pix_eol, pix_data}, exp_q.pop_front());
    end
    prev_rdv = avm_readdatavalid;
    prev_lo  = avm_readdata[23:0];
  end

  // ---------------- monitor B ----------------
  always @(negedge clk_100) begin
    if (avm_read_b && !avm_waitrequest_b && !reset) begin
      n_acc_b++;
      check("b_outstanding_at_accept", 64'(outst_b), 64'd0);
      if (exp_addr_b_q.size() == 0) check("b_extra_burst", avm_address_b, 30'h3FFFFFFF);
      else check("b_burst_addr", avm_address_b, exp_addr_b_q.pop_front());
      outst_b++;
    end else if (outst_b != 0) begin
      check("b_read_held_off", avm_read_b, 1'b0);
    end
    if (pix_valid_b) n_pix_b++;
    if (avm_readdatavalid_b && outst_b != 0) begin
      beats_b++;
      if (beats_b % BL == 0) outst_b--;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_req();
    @(posedge clk_100); #1 line_request = 1'b1;
    @(posedge clk_100); #1 line_request = 1'b0;
  endtask

  task automatic write_done(input logic [1:0] idx);
    @(posedge clk_100); #1 done_write_frame = 1'b1; wr_buf_idx = idx;
    @(posedge clk_100); #1 done_write_frame = 1'b0;
  endtask

  task automatic expect_line(input logic [29:0] a0, input logic [29:0] a1, input bit first);
    logic [63:0] w;
    logic [29:0] base;
    exp_addr_q.push_back(a0);
    exp_addr_q.push_back(a1);
    for (int b = 0; b < 2; b++) begin
      base = (b == 0) ? a0 : a1;
      for (int i = 0; i < BL; i++) begin
        w = mem_word(base + 30'(i));
        exp_q.push_back({first && b == 0 && i == 0, b == 1 && i == BL - 1, w[23:0]});
      end
    end
  endtask

  task automatic wait_line_done(input string name);
    int n = 0;
    @(negedge clk_100);
    while ((busy || exp_q.size() != 0 || exp_addr_q.size() != 0) && n < 300) begin
      @(negedge clk_100);
      n++;
    end
    check(name, 64'(n < 300), 64'd1);
  endtask

  task automatic pulse_when_drain();
    int n = 0;
    while (fsm_state != 2'd3 && n < 100) begin @(negedge clk_100); n++; end
    check("reach_drain", 64'(n < 100), 64'd1);
    line_request = 1'b1;
    @(posedge clk_100); #1 line_request = 1'b0;
  endtask

  task automatic pulse_at_last_beat();
    int n = 0;
    @(negedge clk_100);
    while (!(avm_readdatavalid && rdv_last_a && acc_a_addr.size() == 0) && n < 100) begin
      @(negedge clk_100);
      n++;
    end
    check("reach_last_beat", 64'(n < 100), 64'd1);
    line_request = 1'b1;
    @(posedge clk_100); #1 line_request = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int acc0;
    int pix0;
    int n;

    repeat (3) @(posedge clk_100);
    @(negedge clk_100);
    check("reset_outputs", {rd_buf_idx, frame_buffer_ready, busy, avm_read, pix_valid,
                            pix_sof, pix_eol, count_read_frame, fsm_state}, '0);
    check("reset_avm_address", avm_address, '0);
    check("burstcount", avm_burstcount, 8'd4);
    @(posedge clk_100); #1 reset = 1'b0;

    // Request before any frame exists: ignored
    pulse_req();
    repeat (5) @(posedge clk_100);
    @(negedge clk_100);
    check("early_req_no_accept", 64'(n_acc_a), 64'd0);
    check("early_req_idle", fsm_state, 2'd0);

    // Frame 1 from buffer 1
    write_done(2'd1);
    repeat (2) @(posedge clk_100);
    @(negedge clk_100);
    check("fb_ready", frame_buffer_ready, 1'b1);
    check("state_wait", fsm_state, 2'd1);

    acc0 = n_acc_a;
    expect_line(30'h100000, 30'h100004, 1'b1);
    pulse_req();
    wait_line_done("line0_done");
    check("line0_accepts", 64'(n_acc_a - acc0), 64'd2);
    check("line0_rd_buf", rd_buf_idx, 2'd1);

    // Line 1 with waitrequest held for three cycles on the first burst
    acc0 = n_acc_a;
    avm_waitrequest = 1'b1;
    expect_line(30'h100500, 30'h100504, 1'b0);
    pulse_req();
    repeat (3) begin
      @(negedge clk_100);
      check("stall_read_held", avm_read, 1'b1);
      check("stall_addr_held", avm_address, 30'h100500);
    end
    @(posedge clk_100); #1 avm_waitrequest = 1'b0;
    wait_line_done("line1_done");
    check("line1_accepts", 64'(n_acc_a - acc0), 64'd2);

    // A newer frame completes mid-frame; line 2 still reads buffer 1
    write_done(2'd2);
    expect_line(30'h100A00, 30'h100A04, 1'b0);
    pulse_req();
    wait_line_done("line2_done");
    check("line2_rd_buf", rd_buf_idx, 2'd1);
    check("frame_count_1", count_read_frame, 8'd1);

    // Frame 2 from buffer 2; requests during DRAIN and at DRAIN->WAIT are dropped
    mem_lat_a = 6;
    acc0 = n_acc_a;
    expect_line(30'h200000, 30'h200004, 1'b1);
    pulse_req();
    pulse_when_drain();
    pulse_at_last_beat();
    wait_line_done("f2_line0_done");
    repeat (6) @(posedge clk_100);
    @(negedge clk_100);
    check("drain_req_ignored", 64'(n_acc_a - acc0), 64'd2);
    check("drain_req_state", {busy, fsm_state}, {1'b0, 2'd1});
    check("f2_rd_buf", rd_buf_idx, 2'd2);

    // Reset with one burst outstanding; late beats must not reach the pixel port
    mem_lat_a = 8;
    pix0 = n_pix_a;
    exp_addr_q.push_back(30'h200500);
    pulse_req();
    @(posedge clk_100); #1 avm_waitrequest = 1'b1; reset = 1'b1;
    @(posedge clk_100);
    @(posedge clk_100); #1 reset = 1'b0; avm_waitrequest = 1'b0;
    repeat (20) @(posedge clk_100);
    @(negedge clk_100);
    check("reset_stale_no_pixels", 64'(n_pix_a - pix0), 64'd0);
    check("reset_state", {fsm_state, frame_buffer_ready, busy, avm_read, count_read_frame},
          '0);
    check("reset_slave_drained", 64'(acc_a_addr.size()), 64'd0);

    // Next frame restarts at line 0 of buffer 0
    mem_lat_a = 2;
    write_done(2'd0);
    repeat (2) @(posedge clk_100);
    expect_line(30'h000000, 30'h000004, 1'b1);
    pulse_req();
    wait_line_done("after_reset_line_done");
    check("after_reset_rd_buf", rd_buf_idx, 2'd0);

    // Single-outstanding instance with slow memory
    exp_addr_b_q.push_back(30'h100000);
    exp_addr_b_q.push_back(30'h100004);
    @(posedge clk_100); #1 done_write_frame_b = 1'b1; wr_buf_idx_b = 2'd1;
    @(posedge clk_100); #1 done_write_frame_b = 1'b0;
    repeat (2) @(posedge clk_100);
    #1 line_request_b = 1'b1;
    @(posedge clk_100); #1 line_request_b = 1'b0;
    n = 0;
    while ((n_pix_b < 8 || busy_b) && n < 300) begin @(negedge clk_100); n++; end
    check("b_line_done", 64'(n < 300), 64'd1);
    repeat (4) @(negedge clk_100);
    check("b_accepts", 64'(n_acc_b), 64'd2);
    check("b_pixels", 64'(n_pix_b), 64'd8);
    check("b_addr_queue_empty", 64'(exp_addr_b_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
